// File: rtl/register_fetch_stage.sv
// Register fetch stage: register file with a busy scoreboard, operand bypass from
// writeback, immediate operand formation and a one-deep valid/ready output register.
module register_fetch_stage #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_src_a,
    input  logic [IDX_W-1:0]  in_src_b,
    input  logic [IDX_W-1:0]  in_dst,
    input  logic              in_we,
    input  logic              in_ri,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [IDX_W-1:0]  out_dst,
    output logic              out_we
);

    localparam int REG_COUNT = 2 ** IDX_W;

    logic [DATA_W-1:0]    regs_q [REG_COUNT];
    logic [DATA_W-1:0]    regs_d [REG_COUNT];
    logic [REG_COUNT-1:0] busy_q, busy_d;
    logic [REG_COUNT-1:0] wb_clr_s, busy_eff_s;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_a_q, out_a_d, out_b_q, out_b_d;
    logic [IDX_W-1:0]     out_dst_q, out_dst_d;
    logic                 out_we_q, out_we_d;
    logic                 hazard_s, in_ready_s, fire_s;
    logic [DATA_W-1:0]    opa_s, opb_s;

    // Hazard detection: a busy bit being cleared by this cycle's writeback no longer blocks.
    always_comb begin
        wb_clr_s = '0;
        if (wb_valid) begin
            wb_clr_s[wb_idx] = 1'b1;
        end else begin
            wb_clr_s = '0;
        end
        busy_eff_s = busy_q & ~wb_clr_s;
        hazard_s   = (!in_ri && (busy_eff_s[in_src_a] || busy_eff_s[in_src_b]))
                   || (in_we && busy_eff_s[in_dst]);
        in_ready_s = !rst && (!out_valid_q || out_ready) && !hazard_s;
        fire_s     = in_valid && in_ready_s;
    end

    // Operand selection: immediates in ri mode, otherwise register file with wb bypass.
    always_comb begin
        opa_s = '0;
        opb_s = '0;
        if (in_ri) begin
            opa_s = {{(DATA_W-IDX_W){1'b0}}, in_src_a};
            opb_s = {in_src_b, {(DATA_W-IDX_W){1'b0}}};
        end else begin
            if (wb_valid && (wb_idx == in_src_a)) begin
                opa_s = wb_data;
            end else begin
                opa_s = regs_q[in_src_a];
            end
            if (wb_valid && (wb_idx == in_src_b)) begin
                opb_s = wb_data;
            end else begin
                opb_s = regs_q[in_src_b];
            end
        end
    end

    // Next-state for register file, scoreboard and output bundle.
    always_comb begin
        regs_d      = regs_q;
        busy_d      = busy_eff_s;
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_dst_d   = out_dst_q;
        out_we_d    = out_we_q;
        if (wb_valid) begin
            regs_d[wb_idx] = wb_data;
        end else begin
            regs_d = regs_q;
        end
        if (fire_s) begin
            out_valid_d = 1'b1;
            out_a_d     = opa_s;
            out_b_d     = opb_s;
            out_dst_d   = in_dst;
            out_we_d    = in_we;
            // A destination claimed this cycle wins over a same-index writeback clear.
            if (in_we) begin
                busy_d[in_dst] = 1'b1;
            end else begin
                busy_d = busy_eff_s;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset that discards in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q      <= '{default: '0};
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_dst_q   <= '0;
            out_we_q    <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_dst_q   <= out_dst_d;
            out_we_q    <= out_we_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_dst   = out_dst_q;
    assign out_we    = out_we_q;

endmodule
